// File: rtl/rx_decimator.sv
`default_nettype none
// ============================================================================
// Module   : rx_decimator
// Purpose  : Boxcar integrate-and-dump decimator for rotated I/Q lanes.
//            Optional macro RX_DECIMATOR_SAT_EN: saturating add + sat_flag.
// Revision : 1.0  initial release
// ============================================================================
module rx_decimator #(
    parameter int SAMPLE_W = 16,
    parameter int LANES    = 4,
    parameter int ACC_W    = 32,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SAMPLE_W*LANES-1:0] I_in,
    input  logic [SAMPLE_W*LANES-1:0] Q_in,
    input  logic                      in_valid,
    input  logic                      start,
    input  logic [CNT_W-1:0]          dec_ratio,
    input  logic [CNT_W-1:0]          n_out,
    output logic [ACC_W-1:0]          I_out,
    output logic [ACC_W-1:0]          Q_out,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      done
`ifdef RX_DECIMATOR_SAT_EN
    ,
    output logic                      sat_flag
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [1:0]              r_state;
    logic [CNT_W-1:0]        r_ratio;
    logic [CNT_W-1:0]        r_n_out;
    logic [CNT_W-1:0]        r_cyc_cnt;
    logic [CNT_W-1:0]        r_out_cnt;
    logic                    r_s1_valid;
    logic signed [ACC_W-1:0] r_s1_sum_i;
    logic signed [ACC_W-1:0] r_s1_sum_q;
    logic signed [ACC_W-1:0] r_acc_i;
    logic signed [ACC_W-1:0] r_acc_q;

    logic signed [ACC_W-1:0] w_ext_i [LANES];
    logic signed [ACC_W-1:0] w_ext_q [LANES];
    logic signed [ACC_W-1:0] w_lane_sum_i;
    logic signed [ACC_W-1:0] w_lane_sum_q;
    logic signed [ACC_W-1:0] w_add_i;
    logic signed [ACC_W-1:0] w_add_q;
    logic                    w_blk_end;
    logic                    w_acq_end;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            assign w_ext_i[k] = {{(ACC_W-SAMPLE_W){I_in[k*SAMPLE_W+SAMPLE_W-1]}},
                                 I_in[k*SAMPLE_W +: SAMPLE_W]};
            assign w_ext_q[k] = {{(ACC_W-SAMPLE_W){Q_in[k*SAMPLE_W+SAMPLE_W-1]}},
                                 Q_in[k*SAMPLE_W +: SAMPLE_W]};
        end
    endgenerate

    always_comb begin
        w_lane_sum_i = '0;
        w_lane_sum_q = '0;
        for (int k = 0; k < LANES; k++) begin
            w_lane_sum_i = w_lane_sum_i + w_ext_i[k];
            w_lane_sum_q = w_lane_sum_q + w_ext_q[k];
        end
    end

`ifdef RX_DECIMATOR_SAT_EN
    localparam logic signed [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] w_wide_i;
    logic signed [ACC_W:0] w_wide_q;
    logic                  w_ovf_i;
    logic                  w_ovf_q;
    logic                  r_sat_flag;

    // One guard bit exposes overflow: the top two bits disagree.
    always_comb begin
        w_wide_i = {r_acc_i[ACC_W-1], r_acc_i} + {r_s1_sum_i[ACC_W-1], r_s1_sum_i};
        w_wide_q = {r_acc_q[ACC_W-1], r_acc_q} + {r_s1_sum_q[ACC_W-1], r_s1_sum_q};
        w_ovf_i  = w_wide_i[ACC_W] ^ w_wide_i[ACC_W-1];
        w_ovf_q  = w_wide_q[ACC_W] ^ w_wide_q[ACC_W-1];
        w_add_i  = w_ovf_i ? (w_wide_i[ACC_W] ? c_acc_min : c_acc_max) : w_wide_i[ACC_W-1:0];
        w_add_q  = w_ovf_q ? (w_wide_q[ACC_W] ? c_acc_min : c_acc_max) : w_wide_q[ACC_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_flag <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_sat_flag <= 1'b0;
        end else if (r_state == S_RUN && r_s1_valid && (w_ovf_i || w_ovf_q)) begin
            r_sat_flag <= 1'b1;
        end
    end

    assign sat_flag = r_sat_flag;
`else
    always_comb begin
        w_add_i = r_acc_i + r_s1_sum_i;
        w_add_q = r_acc_q + r_s1_sum_q;
    end
`endif

    assign w_blk_end = r_s1_valid && (r_state == S_RUN) && (r_cyc_cnt + c_one == r_ratio);
    assign w_acq_end = w_blk_end && (r_out_cnt + c_one == r_n_out);
    assign busy      = (r_state == S_RUN) || (r_state == S_FLUSH);

    // Stage 1: lane reduction; samples arriving outside RUN never enter the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sum_i <= '0;
            r_s1_sum_q <= '0;
        end else begin
            r_s1_valid <= in_valid && (r_state == S_RUN);
            r_s1_sum_i <= w_lane_sum_i;
            r_s1_sum_q <= w_lane_sum_q;
        end
    end

    // Stage 2 and acquisition control.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ratio   <= '0;
            r_n_out   <= '0;
            r_cyc_cnt <= '0;
            r_out_cnt <= '0;
            r_acc_i   <= '0;
            r_acc_q   <= '0;
            I_out     <= '0;
            Q_out     <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            done      <= (r_state == S_FIN);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (n_out != '0) begin
                            r_ratio   <= (dec_ratio == '0) ? c_one : dec_ratio;
                            r_n_out   <= n_out;
                            r_cyc_cnt <= '0;
                            r_out_cnt <= '0;
                            r_acc_i   <= '0;
                            r_acc_q   <= '0;
                            r_state   <= S_RUN;
                        end else begin
                            r_state   <= S_FIN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_blk_end) begin
                        I_out     <= w_add_i;
                        Q_out     <= w_add_q;
                        out_valid <= 1'b1;
                        r_acc_i   <= '0;
                        r_acc_q   <= '0;
                        r_cyc_cnt <= '0;
                        r_out_cnt <= r_out_cnt + c_one;
                        if (w_acq_end) begin
                            r_state <= S_FLUSH;
                        end
                    end else if (r_s1_valid) begin
                        r_acc_i   <= w_add_i;
                        r_acc_q   <= w_add_q;
                        r_cyc_cnt <= r_cyc_cnt + c_one;
                    end
                end
                S_FLUSH: r_state <= S_FIN;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
